// File: rtl/hb3_multi_if.sv
// hb3_multi_if: bundle of motor-control request and Pmod pin signals for hb3_multi.
// All signals are plain levels sampled on the rising clock edge; there is no
// valid/ready handshake. Requests may change at any time. The driver applies
// them at the next PWM period (speed) or starts a guarded reversal on the next
// clock (direction_control).
interface hb3_multi_if #(
    parameter int CHANNELS = 2,
    parameter int RES      = 8
);
    logic [CHANNELS*RES-1:0] speed;             // channel k at [k*RES +: RES]
    logic [CHANNELS-1:0]     direction_control; // requested direction
    logic [CHANNELS-1:0]     motor_direction;   // direction pin
    logic [CHANNELS-1:0]     motor_enable;      // PWM enable pin
    logic [CHANNELS-1:0]     reversing;         // channel is in dead time

    // Motor-control side
    modport master (
        output speed, direction_control,
        input  motor_direction, motor_enable, reversing
    );

    // Driver side
    modport slave (
        input  speed, direction_control,
        output motor_direction, motor_enable, reversing
    );
endinterface

// File: rtl/hb3_multi.sv
// hb3_multi: multi-channel H-bridge driver for Pmod HB3-style motor ports.
// A shared prescaler and PWM counter form the timebase. Each channel runs a
// two-state FSM (DRIVE/DEAD). Any direction change is preceded by
// DEAD_CYCLES clocks with enable held low. The per-channel FSM state is
// visible on the reversing output, which is high exactly in DEAD.
// Optional feature macro: HB3_RAMP_EN. When it is defined, the applied duty
// slews toward the request by at most RAMP_STEP per PWM period, and it
// restarts from 0 after each reversal.
module hb3_multi #(
    parameter int CHANNELS    = 2,
    parameter int RES         = 8,
    parameter int PRESCALE    = 1,
    parameter int DEAD_CYCLES = 16,
    parameter int RAMP_STEP   = 4
) (
    input logic        clk,
    input logic        rst,
    hb3_multi_if.slave hb
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [PW-1:0]  PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEAD_CYCLES - 1);
    // Last counter value is 2^RES-2, so one period is 2^RES-1 steps. This lets
    // a full-scale duty (2^RES-1) keep the enable high for the whole period.
    localparam logic [RES-1:0] CNT_LAST  = ~RES'(1);

    typedef enum logic {
        DRIVE = 1'b0,
        DEAD  = 1'b1
    } state_t;

    logic [PW-1:0]  pre_q, pre_d;
    logic [RES-1:0] cnt_q, cnt_d;
    logic           tick;
    logic           period_start;

    state_t         state_q [CHANNELS];
    state_t         state_d [CHANNELS];
    logic [DW-1:0]  dead_q  [CHANNELS];
    logic [DW-1:0]  dead_d  [CHANNELS];
    logic [RES-1:0] duty_q  [CHANNELS];
    logic [RES-1:0] duty_d  [CHANNELS];
    logic [CHANNELS-1:0] dir_q, dir_d;
    logic [CHANNELS-1:0] en_q, en_d;
    logic [CHANNELS-1:0] rev;

`ifdef HB3_RAMP_EN
    localparam logic [RES-1:0] STEP_V = RES'(RAMP_STEP);

    // One slew step toward the target. It lands exactly on the target when
    // the target is within one step, so the duty never overshoots.
    function automatic logic [RES-1:0] ramp_duty(input logic [RES-1:0] cur,
                                                 input logic [RES-1:0] tgt);
        logic [RES-1:0] r;
        if (tgt > cur) begin
            r = ((tgt - cur) > STEP_V) ? (cur + STEP_V) : tgt;
        end else begin
            r = ((cur - tgt) > STEP_V) ? (cur - STEP_V) : tgt;
        end
        return r;
    endfunction
`else
    // The slew step only exists in the ramped build.
    logic unused_ramp_step;
    assign unused_ramp_step = (RAMP_STEP != 0);
`endif

    // Timebase next state: prescaler wrap gives tick; the PWM counter steps on tick
    always_comb begin
        tick         = (pre_q == PRE_LAST);
        pre_d        = tick ? '0 : (pre_q + 1'b1);
        period_start = tick && (cnt_q == CNT_LAST);
        cnt_d        = cnt_q;
        if (tick) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : (cnt_q + 1'b1);
        end
    end

    // Timebase registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

    // Per-channel FSM next state, duty update and registered pin values
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            state_d[k] = state_q[k];
            dead_d[k]  = dead_q[k];
            duty_d[k]  = duty_q[k];
            dir_d[k]   = dir_q[k];
            en_d[k]    = 1'b0;

            if (period_start) begin
`ifdef HB3_RAMP_EN
                duty_d[k] = ramp_duty(duty_q[k], hb.speed[k*RES +: RES]);
`else
                duty_d[k] = hb.speed[k*RES +: RES];
`endif
            end

            case (state_q[k])
                DRIVE: begin
                    if (hb.direction_control[k] != dir_q[k]) begin
                        state_d[k] = DEAD;
                        dead_d[k]  = DEAD_LOAD;
`ifdef HB3_RAMP_EN
                        duty_d[k]  = '0;
`endif
                    end else begin
                        en_d[k] = (cnt_q < duty_q[k]);
                    end
                end
                DEAD: begin
                    // The direction taken is whatever is requested at expiry,
                    // so a request toggled back mid-dead-time keeps the old one.
                    if (dead_q[k] == '0) begin
                        dir_d[k]   = hb.direction_control[k];
                        state_d[k] = DRIVE;
                    end else begin
                        dead_d[k] = dead_q[k] - 1'b1;
                    end
                end
                default: state_d[k] = DRIVE;
            endcase
        end
    end

    // Per-channel registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= DRIVE;
                dead_q[k]  <= '0;
                duty_q[k]  <= '0;
            end
            dir_q <= '0;
            en_q  <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= state_d[k];
                dead_q[k]  <= dead_d[k];
                duty_q[k]  <= duty_d[k];
            end
            dir_q <= dir_d;
            en_q  <= en_d;
        end
    end

    // Dead-time flag decoded straight from the FSM state register
    always_comb begin
        rev = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            rev[k] = (state_q[k] == DEAD);
        end
    end

    assign hb.motor_enable    = en_q;
    assign hb.motor_direction = dir_q;
    assign hb.reversing       = rev;
endmodule

// File: tb/tb_hb3_multi.sv
// tb_hb3_multi: self-checking bench for hb3_multi (CHANNELS=2, RES=8,
// PRESCALE=1, DEAD_CYCLES=16, RAMP_STEP=4). Define HB3_RAMP_EN for both the
// bench and the design to exercise the ramped build.
module tb_hb3_multi;
  localparam int CH   = 2;
  localparam int RES  = 8;
  localparam int PER  = 255;
  localparam int DEAD = 16;
  localparam int STEP = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hb3_multi_if #(.CHANNELS(CH), .RES(RES)) hb ();

  hb3_multi #(
    .CHANNELS(CH), .RES(RES), .PRESCALE(1), .DEAD_CYCLES(DEAD), .RAMP_STEP(STEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hb(hb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Rules: a period is 255 clocks; the duty for a period is chosen from the
  // request at the period start; the enable is high for exactly that many
  // clocks of the period. The bench keeps its own clock count since reset.
  function automatic int next_duty(input int cur, input int tgt);
`ifdef HB3_RAMP_EN
    if (tgt > cur) return (tgt - cur > STEP) ? cur + STEP : tgt;
    return (cur - tgt > STEP) ? cur - STEP : tgt;
`else
    return tgt;
`endif
  endfunction

  typedef struct {
    int ch;
    int act;
    int exp;
  } win_t;

  int cyc;                       // rising edges since reset release
  int duty_m [CH];
  int hi_cnt [CH];
  int last_hi [CH];
  int win_done = 0;
  bit mon_on = 1'b0;
  logic [CH*RES-1:0] exp_q[$];   // duty expected for each upcoming period
  logic [CH*RES-1:0] pk, ex;
  win_t win_log[$];
  int rd_idx = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc = 0;
    else cyc++;
  end

  // Monitor: counts enable-high clocks per period window. The window for
  // period j spans clocks 255j+1 .. 255j+255 after reset.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < CH; k++) begin
        hi_cnt[k] = 0;
        duty_m[k] = 0;
      end
    end else begin
      if (cyc >= PER + 1)
        for (int k = 0; k < CH; k++) hi_cnt[k] += int'(hb.motor_enable[k]);
      if (cyc >= 2 * PER && cyc % PER == 0) begin
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        for (int k = 0; k < CH; k++) begin
          last_hi[k] = hi_cnt[k];
          if (mon_on) win_log.push_back('{k, hi_cnt[k], int'(ex[k*RES +: RES])});
          hi_cnt[k] = 0;
        end
        win_done++;
      end
      if (cyc % PER == PER - 1) begin
        for (int k = 0; k < CH; k++) begin
          duty_m[k] = next_duty(duty_m[k], int'(hb.speed[k*RES +: RES]));
          pk[k*RES +: RES] = RES'(duty_m[k]);
        end
        exp_q.push_back(pk);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_speed(input int s0, input int s1);
    hb.speed = {8'(s1), 8'(s0)};
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_win(input int target);
    int t = 0;
    while (win_done < target && t < 4 * PER) begin
      @(posedge clk); #1;
      t++;
    end
    if (win_done < target) check("win_timeout", win_done, target);
  endtask

  task automatic wait_mod(input int m);
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (cyc % PER != m && t < 2 * PER);
    if (cyc % PER != m) check("mod_timeout", cyc % PER, m);
  endtask

  task automatic drain();
    while (rd_idx < win_log.size()) begin
      check($sformatf("period_hi_ch%0d", win_log[rd_idx].ch),
            win_log[rd_idx].act, win_log[rd_idx].exp);
      rd_idx++;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int s0;
    int s1;
    int hi0;
    int hi1;
  } vec_t;
  vec_t tbl[5];

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int bad;
    int n0;
    int ramp_exp[5];

    tbl[0] = '{128, 255, 128, 255};
    tbl[1] = '{0,   1,   0,   1};
    tbl[2] = '{255, 0,   255, 0};
    tbl[3] = '{64,  192, 64,  192};
    tbl[4] = '{254, 100, 254, 100};
    ramp_exp = '{4, 8, 12, 16, 16};

    rst = 1'b1;
    hb.speed = '0;
    hb.direction_control = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_enable", int'(hb.motor_enable), 0);
    check("rst_direction", int'(hb.motor_direction), 0);
    check("rst_reversing", int'(hb.reversing), 0);
    @(posedge clk); #1 rst = 1'b0;
    mon_on = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if ((hb.motor_enable | hb.motor_direction | hb.reversing) != '0) bad++;
    end
    check("idle_after_reset", bad, 0);
    @(posedge clk); #1;

`ifndef HB3_RAMP_EN
    // table-driven duty vectors
    for (int i = 0; i < 5; i++) begin
      set_speed(tbl[i].s0, tbl[i].s1);
      n0 = win_done;
      wait_win(n0 + 3);
      check($sformatf("tbl%0d_hi0", i), last_hi[0], tbl[i].hi0);
      check($sformatf("tbl%0d_hi1", i), last_hi[1], tbl[i].hi1);
    end

    // mid-period change: current period keeps old duty
    set_speed(64, 64);
    n0 = win_done;
    wait_win(n0 + 3);
    wait_mod(10);
    set_speed(192, 64);
    n0 = win_done;
    wait_win(n0 + 1);
    check("mid_keep_64", last_hi[0], 64);
    wait_win(n0 + 2);
    check("mid_next_192", last_hi[0], 192);
    check("mid_ch1_64", last_hi[1], 64);
`else
    // ramp: 0 -> 16 in steps of 4, then a reversal restarts from 0
    do_reset();
    set_speed(16, 16);
    n0 = win_done;
    for (int j = 1; j <= 5; j++) begin
      wait_win(n0 + j);
      check($sformatf("ramp_step%0d", j), last_hi[0], ramp_exp[j-1]);
    end
    mon_on = 1'b0;
    wait_mod(100);
    hb.direction_control[0] = 1'b1;
    n0 = win_done;
    wait_win(n0 + 2);
    check("ramp_restart_ch0", last_hi[0], 4);
    check("ramp_ch1_kept", last_hi[1], 16);
    check("ramp_dir0", int'(hb.motor_direction[0]), 1);
    hb.direction_control[0] = 1'b0;
`endif

    // randomized speed requests against the period model
    mon_on = 1'b0;
    do_reset();
    mon_on = 1'b1;
    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(20, 400)) @(posedge clk);
      #1 set_speed($urandom_range(0, 255), $urandom_range(0, 255));
    end
    wait_win(win_done + 2);
    mon_on = 1'b0;

`ifndef HB3_RAMP_EN
    // reversal on channel 0 at full speed
    set_speed(255, 255);
    wait_win(win_done + 3);
    @(negedge clk);
    check("full_en", int'(hb.motor_enable), 3);
    @(posedge clk); #1 hb.direction_control[0] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < DEAD; i++) begin
      @(negedge clk);
      check($sformatf("dead_rev0_%0d", i), int'(hb.reversing[0]), 1);
      check($sformatf("dead_en0_%0d", i), int'(hb.motor_enable[0]), 0);
      check($sformatf("dead_dir0_%0d", i), int'(hb.motor_direction[0]), 0);
      check($sformatf("dead_en1_%0d", i), int'(hb.motor_enable[1]), 1);
    end
    @(negedge clk);
    check("flip_rev0", int'(hb.reversing[0]), 0);
    check("flip_dir0", int'(hb.motor_direction[0]), 1);
    check("flip_en0", int'(hb.motor_enable[0]), 0);
    @(negedge clk);
    check("resume_en0", int'(hb.motor_enable[0]), 1);
    check("ch1_dir", int'(hb.motor_direction[1]), 0);
    check("ch1_en", int'(hb.motor_enable[1]), 1);

    // request toggled back at dead cycle 5
    @(posedge clk); #1 hb.direction_control[0] = 1'b0;
    @(posedge clk);
    for (int i = 0; i < DEAD; i++) begin
      @(negedge clk);
      check($sformatf("tb_rev0_%0d", i), int'(hb.reversing[0]), 1);
      check($sformatf("tb_en0_%0d", i), int'(hb.motor_enable[0]), 0);
      if (i == 4) begin
        @(posedge clk); #1 hb.direction_control[0] = 1'b1;
      end
    end
    @(negedge clk);
    check("tb_end_rev0", int'(hb.reversing[0]), 0);
    check("tb_end_dir0", int'(hb.motor_direction[0]), 1);
    @(negedge clk);
    check("tb_resume_en0", int'(hb.motor_enable[0]), 1);

    // asynchronous reset in the middle of dead time
    @(posedge clk); #1 hb.direction_control[0] = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_en", int'(hb.motor_enable), 0);
    check("arst_dir", int'(hb.motor_direction), 0);
    check("arst_rev", int'(hb.reversing), 0);
    @(posedge clk); #1 rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (hb.reversing != '0) bad++;
    end
    check("arst_fsm_drive", bad, 0);
`endif

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hb3_multi.md
# hb3_multi

Parametrised multi-channel H-bridge driver for Pmod HB3-style motor ports. Generates one PWM enable and one direction line per channel from a shared free-running PWM timebase. Every direction reversal is guarded by a dead-time interval with enable forced low, so the bridge never switches direction while driven. Sits between the motor-control logic (speed/direction requests) and the Pmod pins.

## Interface
- `CHANNELS`, 2: number of independent motor channels (1..8).
- `RES`, 8: PWM resolution in bits; width of each speed field.
- `PRESCALE`, 1: clocks per PWM counter step (≥1).
- `DEAD_CYCLES`, 16: clocks of forced-off time on direction change (≥1).
- `RAMP_STEP`, 4: max duty change per PWM period; used only with `HB3_RAMP_EN`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `speed`  in  CHANNELS*RES  requested duty; channel k at bits [k*RES +: RES].
- `direction_control`  in  CHANNELS  requested direction per channel.
- `motor_direction`  out  CHANNELS  direction pin per channel (registered).
- `motor_enable`  out  CHANNELS  PWM enable pin per channel (registered).
- `reversing`  out  CHANNELS  high while channel is in dead time.

## Operation
- Prescaler counts 0..PRESCALE-1; `tick` asserted when it wraps.
- PWM counter `cnt`, RES bits, advances on `tick` over 0..2^RES-2, then wraps to 0 (period = 2^RES-1 steps).
- Period start = tick with `cnt` wrapping to 0. Applied duty `duty[k]` is loaded only at period start; mid-period `speed` changes take effect next period.
- Per-channel FSM, two states:
  - DRIVE: `motor_enable[k]` <= (`cnt` < `duty[k]`). If `direction_control[k]` != `motor_direction[k]` -> DEAD, load dead counter with DEAD_CYCLES-1, `motor_enable[k]` <= 0.
  - DEAD: `motor_enable[k]` held 0, `reversing[k]`=1, counter decrements every clock. At 0: `motor_direction[k]` <= current `direction_control[k]` -> DRIVE.
- Request toggled back during DEAD: dead time still runs to completion; direction set to the value sampled at expiry (may equal the old one).
- Duty arithmetic: duty 0 -> enable never high; duty 2^RES-1 -> enable constantly high; duty d -> high for d of 2^RES-1 steps.
- Channels fully independent; one channel reversing does not affect others.

## Timing
- Reset values: `motor_enable`=0, `motor_direction`=0, `reversing`=0, `cnt`=0, prescaler=0, all `duty`=0, all FSMs DRIVE.
- `motor_enable` lags the `cnt` compare by one clock.
- Direction request to enable-off: 1 clock. Enable off to `motor_direction` flip: DEAD_CYCLES clocks. First possible enable high: 1 clock after the flip.
- `speed` change to output: up to one PWM period plus 1 clock.
- Reset mid-dead-time: outputs to reset values immediately (asynchronous); FSM back to DRIVE.

## Configuration
- `HB3_RAMP_EN` defined: at each period start, `duty[k]` moves toward `speed[k]` by at most RAMP_STEP, saturating at target without overshoot. Entering DEAD clears `duty[k]` to 0, so every reversal restarts from standstill.
- Not defined: `duty[k]` <= `speed[k]` directly at period start. RAMP_STEP ignored.

## Test plan
- Reset: assert `rst` 3 ns into a clock -> all outputs 0 before the next edge; all outputs stay 0 after release with speed=0.
- Duty (RES=8, PRESCALE=1): speed=0x80 -> 128 high clocks per 255-clock period. 0xFF -> enable constantly high. 0x00 -> constantly low.
- Mid-period change: speed 0x40->0xC0 at cnt=10 -> current period keeps 64 high, next period 192.
- Reversal (DEAD_CYCLES=16, speed=0xFF): toggle `direction_control[0]` -> enable[0] low next clock; `reversing[0]` high 16 clocks; direction[0] flips at expiry; channel 1 unaffected.
- Toggle back during DEAD at cycle 5 -> dead time completes, direction[0] unchanged, enable resumes.
- `HB3_RAMP_EN`, RAMP_STEP=4: speed 0->0x10 -> duty 4, 8, 12, 16 over four periods; reversal -> duty restarts from 0.
